// File: rtl/fphub_pkg.sv
// Shared HUB floating-point definitions used by the iterative multiplier and
// the SRT divider: operand classes, FSM states, significand/exponent helpers.
package fphub_pkg;

  // Operand classification; HUB has no subnormals.
  typedef enum logic [1:0] {NORMAL, ZERO, INF} op_class_e;

  // Iterative-unit sequencing states.
  typedef enum logic [1:0] {IDLE, MUL, PACK} mul_state_e;

  // Helpers work on a generous fixed width; callers cast down to their own.
  localparam int FIELD_W = 64;

  // Saturation patterns; slice the low bits needed for a given format.
  localparam logic [FIELD_W-1:0] SAT_ONES = '1;
  localparam logic [FIELD_W-1:0] SAT_ZERO = '0;

  // Exponent bias for an e-bit exponent field.
  function automatic int exp_bias(input int e);
    return (1 << (e - 1)) - 1;
  endfunction

  // Class of an operand from its (zero-extended) e-bit exponent field.
  function automatic op_class_e hub_class(input logic [FIELD_W-1:0] exp_f,
                                          input int e);
    logic [FIELD_W-1:0] ones;
    ones = (FIELD_W'(1) << e) - FIELD_W'(1);
    if (exp_f == SAT_ZERO)  return ZERO;
    else if (exp_f == ones) return INF;
    else                    return NORMAL;
  endfunction

  // HUB significand {1, man, ILSB=1} from an m-bit mantissa field.
  function automatic logic [FIELD_W-1:0] hub_sig(input logic [FIELD_W-1:0] man,
                                                 input int m);
    return (FIELD_W'(1) << (m + 1)) | (man << 1) | FIELD_W'(1);
  endfunction

endpackage

// File: rtl/fphub_seq_multiplier_if.sv
// Issue-slot bundle shared by the HUB iterative units: operands and start in,
// result with finish/computing status out.
interface fphub_seq_multiplier_if #(
  parameter int M = 23,
  parameter int E = 8
);
  localparam int T = M + E;

  logic         start;
  logic [T:0]   x;
  logic [T:0]   y;
  logic [T:0]   res;
  logic         finish;
  logic         computing;
  logic         special_case_detected;

  modport master (
    output start, x, y,
    input  res, finish, computing, special_case_detected
  );

  modport slave (
    input  start, x, y,
    output res, finish, computing, special_case_detected
  );
endinterface

// File: rtl/fphub_mul_special.sv
// Combinational special-operand handling for the HUB multiplier: classifies
// both operands and forms the one-cycle result for zero/infinity inputs.
module fphub_mul_special
  import fphub_pkg::*;
#(
  parameter int M = 23,
  parameter int E = 8
) (
  input  logic         start_i,
  input  logic         computing_i,
  input  logic [M+E:0] x_i,
  input  logic [M+E:0] y_i,
  output logic         special_o,
  output logic         detect_o,
  output logic [M+E:0] res_o
);
  localparam int T = M + E;

  op_class_e cls_x;
  op_class_e cls_y;
  logic      sign;

  assign cls_x     = hub_class(FIELD_W'(x_i[T-1:M]), E);
  assign cls_y     = hub_class(FIELD_W'(y_i[T-1:M]), E);
  assign sign      = x_i[T] ^ y_i[T];
  assign special_o = (cls_x != NORMAL) || (cls_y != NORMAL);
  assign detect_o  = start_i && !computing_i && special_o;

  // Special result: zero*inf is unsigned all-ones, inf wins over finite, zero otherwise.
  always_comb begin
    // NOTE: default assignment first so every path drives res_o; no latch can be inferred.
    res_o = {sign, SAT_ZERO[T-1:0]};
    if ((cls_x == ZERO && cls_y == INF) || (cls_x == INF && cls_y == ZERO))
      res_o = {1'b0, SAT_ONES[T-1:0]};
    else if (cls_x == INF || cls_y == INF)
      res_o = {sign, SAT_ONES[T-1:0]};
  end

endmodule

// File: rtl/fphub_seq_multiplier.sv
// Iterative HUB floating-point multiplier: radix-2 shift-add over the
// significands, then a single normalise/pack cycle. Truncation after
// normalisation is round-to-nearest in HUB format.
module fphub_seq_multiplier
  import fphub_pkg::*;
#(
  parameter int M = 23,
  parameter int E = 8
) (
  input logic                   clk,
  input logic                   rst_l,
  fphub_seq_multiplier_if.slave bus
);
  localparam int T        = M + E;
  localparam int SIG      = M + 2;
  localparam int EXP_BIAS = exp_bias(E);
  localparam int CNT_W    = $clog2(SIG);

  mul_state_e              state_q;
  logic                    sign_q;
  logic signed [E+1:0]     exp_q;
  logic [SIG-1:0]          mcand_q;
  logic [SIG-1:0]          mplier_q;
  logic [SIG:0]            acc_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [T:0]              res_q;
  logic                    finish_q;
  logic                    computing_q;

  logic                    spec_hit;
  logic [T:0]              spec_res;

  logic signed [E+1:0]     exp_start_d;
  logic [SIG:0]            add_d;
  logic [SIG:0]            acc_d;
  logic [SIG-1:0]          mplier_d;
  logic [2*SIG-1:0]        prod_d;
  logic signed [E+1:0]     exp_adj_d;
  logic [M-1:0]            man_d;
  logic [T:0]              pack_res_d;

  fphub_mul_special #(.M(M), .E(E)) u_special (
    .start_i     (bus.start),
    .computing_i (computing_q),
    .x_i         (bus.x),
    .y_i         (bus.y),
    .special_o   (spec_hit),
    .detect_o    (bus.special_case_detected),
    .res_o       (spec_res)
  );

  assign bus.res       = res_q;
  assign bus.finish    = finish_q;
  assign bus.computing = computing_q;

  // Biased product exponent, signed and wide enough that it never wraps.
  assign exp_start_d = (E+2)'(bus.x[T-1:M]) + (E+2)'(bus.y[T-1:M]) - (E+2)'(EXP_BIAS);

  // One shift-add step: conditional add, then shift {acc, mplier} right by one.
  always_comb begin
    add_d    = acc_q + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    acc_d    = {1'b0, add_d[SIG:1]};
    mplier_d = {add_d[0], mplier_q[SIG-1:1]};
  end

  // Normalise the exact product in [1,4), truncate, then clamp the exponent.
  always_comb begin
    prod_d    = {acc_q[SIG-1:0], mplier_q};
    exp_adj_d = exp_q + (E+2)'(prod_d[2*SIG-1]);
    if (prod_d[2*SIG-1]) man_d = prod_d[2*SIG-2 -: M];
    else                 man_d = prod_d[2*SIG-3 -: M];
    if (exp_adj_d[E+1] || exp_adj_d == '0)
      pack_res_d = {sign_q, SAT_ZERO[T-1:0]};
    else if (exp_adj_d[E] || exp_adj_d[E-1:0] == '1)
      pack_res_d = {sign_q, SAT_ONES[T-1:0]};
    else
      pack_res_d = {sign_q, exp_adj_d[E-1:0], man_d};
  end

  // Control FSM and datapath registers; outputs are registered here.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      // NOTE: the datapath registers are reset too, so no stale operand survives an abort.
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      res_q       <= '0;
      finish_q    <= 1'b0;
      computing_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      finish_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (spec_hit) begin
              res_q    <= spec_res;
              finish_q <= 1'b1;
            end else begin
              sign_q      <= bus.x[T] ^ bus.y[T];
              exp_q       <= exp_start_d;
              mcand_q     <= SIG'(hub_sig(FIELD_W'(bus.x[M-1:0]), M));
              mplier_q    <= SIG'(hub_sig(FIELD_W'(bus.y[M-1:0]), M));
              acc_q       <= '0;
              cnt_q       <= '0;
              computing_q <= 1'b1;
              state_q     <= MUL;
            end
          end
        end
        MUL: begin
          acc_q    <= acc_d;
          mplier_q <= mplier_d;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(SIG - 1)) state_q <= PACK;
        end
        PACK: begin
          res_q       <= pack_res_d;
          finish_q    <= 1'b1;
          computing_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fphub_seq_multiplier.sv
// Bench for the HUB iterative multiplier (M=23, E=8): directed corner cases,
// handshake abuse, mid-operation reset and randomized operands against a
// plain-arithmetic reference model.
module tb_fphub_seq_multiplier;

  logic clk = 1'b0;
  logic rst_l;

  always #5 clk = ~clk;

  fphub_seq_multiplier_if #(.M(23), .E(8)) bus ();

  fphub_seq_multiplier #(.M(23), .E(8)) dut (
    .clk   (clk),
    .rst_l (rst_l),
    .bus   (bus.slave)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_special(input logic [31:0] a, input logic [31:0] b);
    return (a[30:23] == 8'h00) || (a[30:23] == 8'hFF) ||
           (b[30:23] == 8'h00) || (b[30:23] == 8'hFF);
  endfunction

  // Reference: full-precision integer product of HUB significands, then rules.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    int              ea, eb, e;
    bit              s, za, zb, ia, ib;
    longint unsigned sa, sb, p;
    logic [31:0]     man;
    logic [31:0]     ev;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    s  = a[31] ^ b[31];
    za = (ea == 0);   zb = (eb == 0);
    ia = (ea == 255); ib = (eb == 255);
    if ((za && ib) || (ia && zb)) return 32'h7FFF_FFFF;
    if (ia || ib)                 return {s, 31'h7FFF_FFFF};
    if (za || zb)                 return {s, 31'h0};
    sa = (64'd1 << 24) + (64'(a[22:0]) << 1) + 64'd1;
    sb = (64'd1 << 24) + (64'(b[22:0]) << 1) + 64'd1;
    p  = sa * sb;
    e  = ea + eb - 127;
    if (p >= (64'd1 << 49)) begin
      p = p >> 1;
      e = e + 1;
    end
    man = 32'((p >> 25) & 64'h7F_FFFF);
    if (e <= 0)   return {s, 31'h0};
    if (e >= 255) return {s, 31'h7FFF_FFFF};
    ev = 32'(e);
    return {s, ev[7:0], man[22:0]};
  endfunction

  // Issue one operation; optionally pulse a second start when lat == inj.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int inj,
                        input logic [31:0] ia, input logic [31:0] ib,
                        output logic [31:0] r, output int lat, output int comp,
                        output logic det_s, output logic det_i);
    @(negedge clk);
    bus.x     = a;
    bus.y     = b;
    bus.start = 1'b1;
    #1 det_s  = bus.special_case_detected;
    det_i     = 1'b0;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat  = 1;
    comp = 0;
    while (!bus.finish && lat < 200) begin
      if (bus.computing) comp++;
      if (lat == inj) begin
        bus.x     = ia;
        bus.y     = ib;
        bus.start = 1'b1;
        #1 det_i  = bus.special_case_detected;
      end
      @(posedge clk);
      #1 bus.start = 1'b0;
      lat++;
    end
    r = bus.res;
  endtask

  // Run one vector and check result, latency, busy time, detect flag and hold.
  task automatic apply(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_r);
    logic [31:0] r;
    int          lat, comp;
    logic        det_s, det_i;
    bit          sp;
    sp = is_special(a, b);
    run_op(a, b, 0, 32'h0, 32'h0, r, lat, comp, det_s, det_i);
    check({tag, ".res"},     r,              exp_r);
    check({tag, ".latency"}, 32'(lat),       sp ? 32'd1 : 32'd27);
    check({tag, ".busy"},    32'(comp),      sp ? 32'd0 : 32'd26);
    check({tag, ".detect"},  32'(det_s),     32'(sp));
    @(posedge clk);
    #1;
    check({tag, ".pulse"},   32'(bus.finish), 32'd0);
    check({tag, ".hold"},    bus.res,         exp_r);
  endtask

  initial begin
    logic [31:0] r, a, b;
    int          lat, comp, extra;
    logic        det_s, det_i;

    rst_l     = 1'b0;
    bus.start = 1'b0;
    bus.x     = '0;
    bus.y     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.res",       bus.res,                32'h0);
    check("reset.finish",    32'(bus.finish),        32'd0);
    check("reset.computing", 32'(bus.computing),     32'd0);
    @(negedge clk);
    rst_l = 1'b1;

    apply("two_sq",     32'h4000_0000, 32'h4000_0000, 32'h4080_0001);
    apply("norm_shift", 32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000);
    apply("neg",        32'hC000_0000, 32'h4000_0000, 32'hC080_0001);
    apply("zero_x",     32'h0000_0000, 32'h4000_0000, 32'h0000_0000);
    apply("inf_zero",   32'h7F80_0000, 32'h0000_0000, 32'h7FFF_FFFF);
    apply("ninf_x",     32'hFF80_0000, 32'h4000_0000, 32'hFFFF_FFFF);
    apply("overflow",   32'h7F00_0000, 32'h7F00_0000, 32'h7FFF_FFFF);
    apply("underflow",  32'h8080_0000, 32'h0080_0000, 32'h8000_0000);

    // A special-operand start during MUL must be ignored and not flagged.
    run_op(32'h4000_0000, 32'h4000_0000, 10, 32'h0000_0000, 32'h4000_0000,
           r, lat, comp, det_s, det_i);
    check("mid_mul.res",     r,           32'h4080_0001);
    check("mid_mul.latency", 32'(lat),    32'd27);
    check("mid_mul.detect",  32'(det_i),  32'd0);

    // A start in the PACK cycle must not launch a second operation.
    run_op(32'h3FC0_0000, 32'h3FC0_0000, 26, 32'h4000_0000, 32'h4000_0000,
           r, lat, comp, det_s, det_i);
    check("in_pack.res",     r,          32'h4010_0000);
    check("in_pack.latency", 32'(lat),   32'd27);
    extra = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (bus.computing || bus.finish) extra++;
    end
    check("in_pack.ignored", 32'(extra), 32'd0);

    // Reset ten cycles into an operation: outputs clear, no finish ever appears.
    @(negedge clk);
    bus.x     = 32'h4000_0000;
    bus.y     = 32'h4000_0000;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst_l = 1'b0;
    #1;
    check("abort.res",       bus.res,            32'h0);
    check("abort.finish",    32'(bus.finish),    32'd0);
    check("abort.computing", 32'(bus.computing), 32'd0);
    @(negedge clk);
    rst_l = 1'b1;
    extra = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.finish) extra++;
    end
    check("abort.no_finish", 32'(extra), 32'd0);
    apply("after_abort", 32'h4000_0000, 32'h4000_0000, 32'h4080_0001);

    // Randomized operands, mostly normal with moderate exponents.
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 9) != 0) a[30:23] = 8'($urandom_range(64, 190));
      if ($urandom_range(0, 9) != 0) b[30:23] = 8'($urandom_range(64, 190));
      if ($urandom_range(0, 11) == 0) b[30:23] = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
      apply($sformatf("rand%0d", i), a, b, ref_mul(a, b));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/fphub_seq_multiplier.md
Name: fphub_seq_multiplier

Overview:
- Iterative floating-point multiplier for HUB format. It is the inverse-operation companion to the SRT divider.
- Uses the same start/finish/computing handshake and the same operand packing, so both units can share an issue slot in the FP datapath.
- Computes the product with a radix-2 shift-add over the significands.
- HUB round-to-nearest is obtained by truncation after normalisation.

Parameters:
- M, default 23: stored mantissa width.
- E, default 8: exponent width.
- T (localparam), M+E: operand MSB index. Operands are T+1 bits wide.
- SIG (localparam), M+2: HUB significand width (implicit 1 + M bits + ILSB=1).
- EXP_BIAS (localparam), 2^(E-1)-1: exponent bias.

Ports:
- clk  in  1  clock
- rst_l  in  1  reset, asynchronous, active-low
- start  in  1  request. Sampled only when computing=0.
- x  in  T+1  operand {sign, exp[E-1:0], man[M-1:0]}
- y  in  T+1  operand, same format
- res  out  T+1  result. Valid when finish=1; held until the next accepted start.
- finish  out  1  one-cycle pulse, result ready
- computing  out  1  high while the iteration or pack phase is in progress
- special_case_detected  out  1  combinational: start & !computing & (x or y special)

Behaviour:
- Reset, asynchronous, any state:
  - state=IDLE.
  - res=0, finish=0, computing=0.
  - Accumulator, multiplier register and counter cleared.
  - An operation in flight is discarded; no finish is produced.
- Operand classes:
  - exp==0 is zero.
  - exp==all-ones is infinity (mantissa ignored).
  - Anything else is normal. There are no subnormals.
  - Significand = {1, man, 1}, SIG bits.
- Special path: start while IDLE and special_case_detected. Next edge: res=special result, finish=1, state stays IDLE. Latency is 1 cycle. Special results:
  - zero x finite: {sx^sy, 0}
  - inf x nonzero: {sx^sy, all-ones}
  - zero x inf: {0, all-ones}
- Normal path states: IDLE -> MUL -> PACK -> IDLE.
- IDLE, on start and not special:
  - Latch sign = sx^sy.
  - Latch exp_tmp = ex+ey-EXP_BIAS, signed E+2 bits.
  - Latch mcand = sig(x), mplier = sig(y), acc=0, cnt=0.
  - computing=1, finish=0.
- MUL, one multiplier bit per cycle, LSB first, SIG cycles:
  - If mplier[0], add mcand into acc.
  - Shift the {acc, mplier} pair right by 1.
  - The product is exact, 2*SIG bits. There is no truncation inside the loop.
  - When cnt==SIG-1, go to PACK.
- PACK, one cycle:
  - Product p is in [1,4). If p[2*SIG-1]=1, shift right by 1 and exp_tmp+=1.
  - Mantissa = the M bits below the leading 1 (truncation, which is HUB nearest).
  - exp_tmp<=0: res={sign, 0} (underflow).
  - exp_tmp>=2^E-1: res={sign, all-ones} (overflow saturate).
  - Otherwise res={sign, exp_tmp[E-1:0], man}.
  - finish=1, computing=0, return to IDLE.
- Normal latency: start edge to finish is SIG+2 cycles (25+2 = 27 for the defaults).
- finish is high for exactly one cycle and then drops. res is held afterwards.
- start while computing=1 is ignored and does not disturb the operation. special_case_detected stays 0 during this time.
- start in the same cycle as finish (PACK) is ignored. The next start is accepted only when IDLE.
- Width rules:
  - acc is SIG+1 bits, to hold the carry.
  - Exponent arithmetic is signed E+2 bits with no wrap.

Decomposition:
- Shared package fphub_pkg:
  - Operand class enum (NORMAL, ZERO, INF).
  - Functions hub_sig(), hub_class() and exp_bias(E).
  - Saturation constants.
  - The divider and the multiplier both reference this package.
- Sub-module fphub_mul_special (combinational): classifies x and y and produces the special result and the detect flag.
- The shift-add datapath and the FSM stay in the top module.

Test Plan:
- x=0x40000000, y=0x40000000 -> res=0x40800001; finish exactly 27 cycles after start; computing high for 26 cycles.
- x=0x3FC00000, y=0x3FC00000 -> normalisation shift taken; res=0x40100000.
- x=0xC0000000, y=0x40000000 -> res=0xC0800001. Then x=0x00000000, y=0x40000000 -> special_case_detected=1 in the start cycle; res=0x00000000 with finish one cycle later.
- x=0x7F800000, y=0x00000000 -> res=0x7FFFFFFF. Then x=0xFF800000, y=0x40000000 -> res=0xFFFFFFFF.
- x=0x7F000000, y=0x7F000000 -> overflow, res=0x7FFFFFFF. Then x=0x80800000, y=0x00800000 -> underflow, res=0x80000000.
- Pulse start with new operands mid-MUL -> ignored, original result returned. Assert rst_l low at cycle 10 -> all outputs 0 and no finish; the next start completes normally.
